// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and defaults for the APB request arbiter
package apb_arb_pkg;

  localparam int NUM_REQ_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 16;
  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - requester side and APB manager side signals of the arbiter
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = apb_arb_pkg::NUM_REQ_DEF
);
  import apb_arb_pkg::*;

  // requester side
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             ack;
  logic [DATA_W-1:0]              rsp_rdata;
  logic                           rsp_err;

  // APB manager side
  logic                           transfer;
  logic                           write;
  logic [ADDR_W-1:0]              addr;
  logic [DATA_W-1:0]              wdata;
  logic [DATA_W-1:0]              rdata;
  logic                           ready;

  modport master (
    input  req, req_write, req_addr, req_wdata, rdata, ready,
    output ack, rsp_rdata, rsp_err, transfer, write, addr, wdata
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, rdata, ready,
    input  ack, rsp_rdata, rsp_err, transfer, write, addr, wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               grant_valid
);

  logic [IDX_W-1:0] cand;

  // walk from last_grant+1 around the ring and take the first active request
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!grant_valid && req[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - shares one APB manager between NUM_REQ requesters, round-robin
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_req_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   last_grant, gnt_idx, grant;
  logic               grant_valid;
  logic               timed_out;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic               transfer_c;
  logic [NUM_REQ-1:0] ack_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req         (bus.req),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // state register; reset abandons any transfer in flight without an ack
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // next state plus the single-cycle transfer and ack strobes
  always_comb begin
    state_nxt  = state;
    transfer_c = 1'b0;
    ack_c      = '0;
    timed_out  = 1'b0;
    case (state)
      ST_IDLE:  if (grant_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        transfer_c = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.ready) begin
          state_nxt = ST_RESP;
        end else if (tmo_cnt >= CNT_LAST) begin
          timed_out = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        ack_c[gnt_idx] = 1'b1;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // payload latch at grant, WAIT-cycle counter and response capture
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      last_grant <= LAST_RST;
      gnt_idx    <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            gnt_idx    <= grant;
            last_grant <= grant;
            write_q    <= bus.req_write[grant];
            addr_q     <= bus.req_addr[grant];
            wdata_q    <= bus.req_wdata[grant];
          end
        end
        ST_ISSUE: tmo_cnt <= '0;
        ST_WAIT: begin
          if (bus.ready) begin
            rdata_q <= bus.rdata;
            err_q   <= 1'b0;
          end else if (timed_out) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (tmo_cnt != CNT_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.transfer  = transfer_c;
  assign bus.ack       = ack_c;
  assign bus.write     = write_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the single APB manager.
REQ-002 Parameter TIMEOUT_CYC, default 16, maximum WAIT cycles before forced error completion.
REQ-003 PCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 PRESET  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NUM_REQ  per-requester transfer request, level, held until ack.
REQ-006 req_write  input  NUM_REQ  per-requester direction, 1 = write.
REQ-007 req_addr  input  NUM_REQ x 32  per-requester address.
REQ-008 req_wdata  input  NUM_REQ x 32  per-requester write data.
REQ-009 ack  output  NUM_REQ  one-hot, one-cycle completion pulse to the served requester.
REQ-010 rsp_rdata  output  32  read data, valid only while any ack bit is 1.
REQ-011 rsp_err  output  1  timeout flag, valid only while any ack bit is 1.
REQ-012 transfer  output  1  start pulse to APB manager.
REQ-013 write  output  1  direction to APB manager.
REQ-014 addr  output  32  address to APB manager.
REQ-015 wdata  output  32  write data to APB manager.
REQ-016 rdata  input  32  read data from APB manager.
REQ-017 ready  input  1  completion from APB manager.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req bit = 1, register the winner's index, write, addr and wdata, then go to ISSUE. Otherwise stay in IDLE.
REQ-020 ISSUE: transfer = 1 for exactly this one cycle, then go to WAIT.
REQ-021 WAIT: on ready = 1, capture rdata into rsp_rdata, set rsp_err = 0 and go to RESP.
REQ-022 WAIT: after TIMEOUT_CYC cycles without ready, set rsp_err = 1 and rsp_rdata = 32'h0, then go to RESP.
REQ-023 RESP: ack[grant] = 1 for one cycle, then go to IDLE. Minimum request-to-request spacing is therefore 4 cycles.
REQ-024 Arbitration: round-robin. The search starts at (last_grant + 1) mod NUM_REQ. last_grant updates only on entry to ISSUE.
REQ-025 write, addr and wdata hold the latched values from ISSUE through RESP. Later changes on req_* inputs have no effect on the transfer in flight.
REQ-026 ready while in IDLE, ISSUE or RESP is ignored.
REQ-027 A requester whose req is still 1 in the cycle after its ack is treated as a new request, at lowest round-robin priority.
REQ-028 A req bit that drops before grant is never served and never receives an ack.
REQ-029 Timeout counter: width clog2(TIMEOUT_CYC+1). Clears on entry to WAIT and saturates, never wraps.
REQ-030 ack is 0 in every state except RESP. transfer is 0 in every state except ISSUE.

Reset
REQ-031 Reset asserted (asynchronous):
- state = IDLE
- transfer = 0, write = 0, addr = 0, wdata = 0
- ack = 0, rsp_rdata = 0, rsp_err = 0
- timeout counter = 0
- last_grant = NUM_REQ-1, so requester 0 wins first
REQ-032 Reset asserted during WAIT abandons the transfer. The aborted requester receives no ack.
REQ-033 Reset is released synchronously to PCLK. Arbitration begins on the first edge after release.

Structure
REQ-034 Package apb_arb_pkg holds:
- state enum arb_state_e
- NUM_REQ and TIMEOUT_CYC defaults
- ADDR_W = 32 and DATA_W = 32
REQ-035 The round-robin grant logic is sub-module rr_arbiter.
- inputs: req vector, last_grant
- outputs: grant index, grant_valid
- purely combinational; the pointer register lives in the parent.

Verification
REQ-036 Single write: req[0] with addr 0x1000_0000 and wdata 0x1234_5678.
- transfer pulses once, one cycle after grant.
- ack[0] pulses one cycle after ready.
- A following read by req[0] returns 0x1234_5678.
REQ-037 Four simultaneous writes: req = 4'b1111 targeting 0x1000_0000, 0x1000_1000, 0x1000_2000 and 0x1000_3000 with 0x12345678, 0xDEADBEEF, 0xCAFEBABE and 0x87654321.
- Service order is 0, 1, 2, 3.
- Read-back of each address returns its written value.
REQ-038 Fairness: req[1] and req[2] held permanently high.
- Grants alternate 1, 2, 1, 2.
- No requester waits more than NUM_REQ-1 transfers.
REQ-039 Timeout: ready held at 0.
- ack pulses with rsp_err = 1 and rsp_rdata = 0 exactly TIMEOUT_CYC cycles after entering WAIT.
- The next request is then served normally.
REQ-040 Payload stability: req_addr changes during WAIT.
- addr output stays at the value latched in ISSUE.
- A spurious ready in IDLE produces no ack.
REQ-041 Reset during WAIT: PRESET = 0 mid-transfer.
- All outputs go to 0 immediately.
- No ack is issued.
- After release, requester 0 wins first.
